// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader and its output buffer.
package rom_stream_reader_pkg;

    localparam int ROM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// Output buffer: synchronous FIFO, head visible combinationally, one-cycle push/pop.
// The caller guarantees no push when full and no pop when empty.
module rom_stream_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [PTR_W:0]   occupancy
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ_q;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
                2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_dat  = mem[rd_ptr];
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Streams count consecutive ROM words from start_addr; first m_valid 3 cycles after start.
// Issues reads only when buffer occupancy plus the in-flight read leaves room, so m_ready stalls never drop data.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int MEM_WORDS   = 8192,
    parameter int FIFO_DEPTH  = 4,
    localparam int ADR_WIDTH  = $clog2(MEM_WORDS)
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      start,
    input  logic [ADR_WIDTH-1:0]      start_addr,
    input  logic [ADR_WIDTH:0]        count,
    output logic                      busy,
    output logic                      done,
    output logic                      rom_en,
    output logic [ADR_WIDTH-1:0]      rom_a,
    input  logic [ROM_DATA_WIDTH-1:0] rom_do,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ROM_DATA_WIDTH-1:0] m_data
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    state_t               state_q, state_d;
    logic [ADR_WIDTH-1:0] addr_q, addr_d;
    logic [ADR_WIDTH:0]   rem_q, rem_d;
    logic [ADR_WIDTH-1:0] last_a_q;
    logic                 in_flight_q;

    logic                 fifo_empty;
    logic [OCC_W-1:0]     occupancy;
    logic [OCC_W:0]       used;
    logic                 credit_ok;
    logic                 pop;
    logic [ADR_WIDTH-1:0] addr_next;

    assign pop       = m_valid & m_ready;
    assign used      = {1'b0, occupancy} + {{OCC_W{1'b0}}, in_flight_q};
    assign credit_ok = (used < (OCC_W+1)'(FIFO_DEPTH));
    assign addr_next = (addr_q == ADR_WIDTH'(MEM_WORDS - 1)) ? '0 : addr_q + ADR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rom_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = start_addr;
                    rem_d  = count;
                    // An empty transfer passes through DRAIN so done lands two cycles after start.
                    state_d = (count == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (credit_ok) begin
                    rom_en = 1'b1;
                    addr_d = addr_next;
                    rem_d  = rem_q - (ADR_WIDTH+1)'(1);
                    if (rem_q == (ADR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave as the last word pops so FINISH follows the final pop directly.
                if (!in_flight_q && (fifo_empty || (occupancy == OCC_W'(1) && pop))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            last_a_q    <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            in_flight_q <= rom_en;
            if (rom_en) begin
                last_a_q <= addr_q;
            end
        end
    end

    assign rom_a = rom_en ? addr_q : last_a_q;

    rom_stream_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ROM_DATA_WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESETn),
        .push      (in_flight_q),
        .push_dat  (rom_do),
        .pop       (pop),
        .head_dat  (m_data),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM model, vector table, reset corner case and random transfers.
module tb_rom_stream_reader;

    localparam int MEM = 8192;
    localparam int ADR = 13;
    localparam int FD  = 4;

    logic            CLK;
    logic            RESETn;
    logic            start;
    logic [ADR-1:0]  start_addr;
    logic [ADR:0]    count;
    logic            busy;
    logic            done;
    logic            rom_en;
    logic [ADR-1:0]  rom_a;
    logic [31:0]     rom_do;
    logic            m_valid;
    logic            m_ready;
    logic [31:0]     m_data;

    logic [31:0] rom_mem [MEM];

    int checks = 0;
    int errors = 0;

    rom_stream_reader #(.MEM_WORDS(MEM), .FIFO_DEPTH(FD)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_a      (rom_a),
        .rom_do     (rom_do),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROM: registered data, zero when not enabled.
    always @(posedge CLK) begin
        rom_do <= rom_en ? rom_mem[rom_a] : 32'h0;
    end

    typedef struct {
        int          sa;
        int          cnt;
        int          mode;      // 0 ready high, 1 random ready, 2 toggle with long stall
        bit          restart;
        bit          has_exp;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_done;  // cycle of done after acceptance, 0 = not checked
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic run_transfer(input vec_t v);
        int          k, issued, pops, done_cyc, budget;
        logic [31:0] exp_q[$];
        logic [31:0] first_w, last_w, w, prev_data;
        bit          prev_stall, rdy, finished;
        for (int i = 0; i < v.cnt; i++) begin
            exp_q.push_back(rom_mem[(v.sa + i) % MEM]);
        end
        k = 0; issued = 0; pops = 0; done_cyc = 0;
        first_w = '0; last_w = '0; prev_data = '0;
        prev_stall = 0; finished = 0;
        budget = v.cnt * 4 + 50;
        @(negedge CLK);
        start      = 1'b1;
        start_addr = ADR'(v.sa);
        count      = (ADR+1)'(v.cnt);
        m_ready    = 1'b1;
        while (!finished) begin
            @(negedge CLK);
            k++;
            if (k == 1) start = 1'b0;
            if (v.restart && k == 3) begin
                start = 1'b1; start_addr = 13'h700; count = 14'd3;
            end
            if (v.restart && k == 4) start = 1'b0;
            if (rom_en) begin
                chk("credit", 32'((issued - pops) < FD), 32'd1);
                chk("rom_a", 32'(rom_a), 32'((v.sa + issued) % MEM));
                chk("issue_limit", 32'(issued + 1 <= v.cnt), 32'd1);
                issued++;
            end
            if (done) begin
                done_cyc = k;
                chk("busy_at_done", 32'(busy), 32'd0);
                finished = 1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", m_data, prev_data);
            end
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (k >= 6 && k < 12) ? 1'b0 : 1'(k % 2);
            endcase
            if (m_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(pops + 1), 32'(v.cnt));
                end else begin
                    w = exp_q.pop_front();
                    chk("m_data", m_data, w);
                end
                if (v.mode == 0) chk("pop_cycle", 32'(k), 32'(3 + pops));
                if (pops == 0) first_w = m_data;
                last_w = m_data;
                pops++;
            end
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
            m_ready    = rdy;
            if (!finished && k >= budget) begin
                chk("timeout", 32'(k), 32'(budget + 1));
                finished = 1;
            end
        end
        chk("words", 32'(pops), 32'(v.cnt));
        chk("issues", 32'(issued), 32'(v.cnt));
        if (v.has_exp && v.cnt > 0) begin
            chk("first_word", first_w, v.exp_first);
            chk("last_word", last_w, v.exp_last);
        end
        if (v.exp_done != 0) chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        repeat (2) begin
            @(negedge CLK);
            chk("done_once", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_en", 32'(rom_en), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_a", 32'(rom_a), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
    endtask

    initial begin
        vec_t rv;
        RESETn = 1'b0; start = 1'b0; start_addr = '0; count = '0; m_ready = 1'b0;
        for (int i = 0; i < MEM; i++) rom_mem[i] = 32'hA500_0000 + 32'(i);
        #12;
        chk_reset_outputs();
        @(negedge CLK);
        RESETn = 1'b1;

        vecs[0] = '{sa: 'h10,    cnt: 8,   mode: 0, restart: 0, has_exp: 1, exp_first: 32'hA500_0010, exp_last: 32'hA500_0017, exp_done: 11};
        vecs[1] = '{sa: 'h10,    cnt: 8,   mode: 2, restart: 0, has_exp: 1, exp_first: 32'hA500_0010, exp_last: 32'hA500_0017, exp_done: 0};
        vecs[2] = '{sa: MEM - 2, cnt: 4,   mode: 0, restart: 0, has_exp: 1, exp_first: 32'hA500_1FFE, exp_last: 32'hA500_0001, exp_done: 7};
        vecs[3] = '{sa: 'h20,    cnt: 0,   mode: 0, restart: 0, has_exp: 0, exp_first: 32'h0,         exp_last: 32'h0,         exp_done: 2};
        vecs[4] = '{sa: 'h30,    cnt: 8,   mode: 0, restart: 1, has_exp: 1, exp_first: 32'hA500_0030, exp_last: 32'hA500_0037, exp_done: 11};
        vecs[5] = '{sa: 'h100,   cnt: 1,   mode: 0, restart: 0, has_exp: 1, exp_first: 32'hA500_0100, exp_last: 32'hA500_0100, exp_done: 4};
        vecs[6] = '{sa: MEM - 1, cnt: 3,   mode: 1, restart: 0, has_exp: 1, exp_first: 32'hA500_1FFF, exp_last: 32'hA500_0001, exp_done: 0};
        vecs[7] = '{sa: 0,       cnt: MEM, mode: 0, restart: 0, has_exp: 1, exp_first: 32'hA500_0000, exp_last: 32'hA500_1FFF, exp_done: MEM + 3};

        for (int i = 0; i < 8; i++) begin
            run_transfer(vecs[i]);
        end

        // Reset with three words buffered and one read in flight.
        @(negedge CLK);
        start = 1'b1; start_addr = 13'h40; count = 14'd16; m_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_head", m_data, 32'hA500_0040);
        RESETn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge CLK);
        RESETn = 1'b1;
        rv = '{sa: 'h50, cnt: 5, mode: 1, restart: 0, has_exp: 1, exp_first: 32'hA500_0050, exp_last: 32'hA500_0054, exp_done: 0};
        run_transfer(rv);

        // Random content, addresses, counts and backpressure.
        for (int i = 0; i < MEM; i++) rom_mem[i] = $urandom;
        for (int t = 0; t < 20; t++) begin
            rv.sa      = int'($urandom_range(0, MEM - 1));
            rv.cnt     = (t % 5 == 0) ? 0 : int'($urandom_range(1, 40));
            rv.mode    = (t % 3 == 0) ? 0 : 1;
            rv.restart = (t % 4 == 1);
            rv.has_exp = 0;
            rv.exp_first = '0;
            rv.exp_last  = '0;
            rv.exp_done  = (rv.mode == 0) ? ((rv.cnt == 0) ? 2 : rv.cnt + 3) : 0;
            run_transfer(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
